// File: rtl/nrisc_decode_stage.sv
// nRisc decode/register stage: opcode decode into datapath controls, 8x8 register
// file with r0 hardwired to zero, and a sticky HALT flag cleared only by Reset.
//
// state  | meaning
// RUN    | decoding normally, controls follow the opcode
// HALTED | HALT seen; every control output forced to 0 until Reset
module nrisc_decode_stage (
    input  logic       Clock,
    input  logic       Reset,
    input  logic [7:0] Instrucao,
    input  logic [7:0] DadoEscritoReg,
    output logic       MemToReg,
    output logic       EscMem,
    output logic       LerMem,
    output logic       Branch,
    output logic       ULAFonte,
    output logic       EscReg,
    output logic       Jump,
    output logic       EscPc,
    output logic       MoveReg,
    output logic       RegDest,
    output logic [1:0] ULAOp,
    output logic [2:0] RegLido1,
    output logic [2:0] RegEscrito,
    output logic [7:0] DadoLido1,
    output logic [7:0] DadoLido2,
    output logic [7:0] Dadoa0
);

    typedef enum logic {
        RUN    = 1'b0,
        HALTED = 1'b1
    } haltState_t;

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_LW   = 3'b010;
    localparam logic [2:0] OP_SW   = 3'b011;
    localparam logic [2:0] OP_BEQ  = 3'b100;
    localparam logic [2:0] OP_J    = 3'b101;
    localparam logic [2:0] OP_MOV  = 3'b110;
    localparam logic [2:0] OP_HALT = 3'b111;

    localparam logic [1:0] ULA_ADD = 2'b00;
    localparam logic [1:0] ULA_SUB = 2'b01;

    haltState_t state;
    haltState_t nextState;

    logic [2:0] opcode;
    logic [2:0] regLido2;
    logic [7:0] regFile [0:7];

    assign opcode   = Instrucao[7:5];
    assign regLido2 = Instrucao[2:0];

    // Halt flag: state register
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state <= RUN;
        end else begin
            state <= nextState;
        end
    end

    // Halt flag: next state
    always_comb begin
        nextState = state;
        if (state == RUN && opcode == OP_HALT) begin
            nextState = HALTED;
        end
    end

    // Control decode; HALT opcode and HALTED state both leave everything at 0
    always_comb begin
        MemToReg = 1'b0;
        EscMem   = 1'b0;
        LerMem   = 1'b0;
        Branch   = 1'b0;
        ULAFonte = 1'b0;
        EscReg   = 1'b0;
        Jump     = 1'b0;
        EscPc    = 1'b0;
        MoveReg  = 1'b0;
        RegDest  = 1'b0;
        ULAOp    = ULA_ADD;
        if (state == RUN) begin
            EscPc = 1'b1;
            case (opcode)
                OP_ADD: begin
                    EscReg = 1'b1;
                    ULAOp  = ULA_ADD;
                end
                OP_SUB: begin
                    EscReg = 1'b1;
                    ULAOp  = ULA_SUB;
                end
                OP_LW: begin
                    LerMem   = 1'b1;
                    MemToReg = 1'b1;
                    EscReg   = 1'b1;
                    ULAFonte = 1'b1;
                    ULAOp    = ULA_ADD;
                end
                OP_SW: begin
                    EscMem   = 1'b1;
                    ULAFonte = 1'b1;
                    ULAOp    = ULA_ADD;
                end
                OP_BEQ: begin
                    Branch = 1'b1;
                    ULAOp  = ULA_SUB;
                end
                OP_J: begin
                    Jump = 1'b1;
                end
                OP_MOV: begin
                    MoveReg = 1'b1;
                    EscReg  = 1'b1;
                    RegDest = 1'b1;
                end
                OP_HALT: begin
                    EscPc = 1'b0;
                end
                default: begin
                    EscPc = 1'b0;
                end
            endcase
        end
    end

    assign RegLido1   = {1'b0, Instrucao[4:3]};
    assign RegEscrito = RegDest ? 3'b001 : RegLido1;

    // Entry 0 is never written, so it stays at its reset value of zero
    always_ff @(posedge Clock) begin
        if (Reset) begin
            for (int i = 0; i < 8; i++) begin
                regFile[i] <= 8'h00;
            end
        end else if (EscReg && RegEscrito != 3'b000) begin
            regFile[RegEscrito] <= DadoEscritoReg;
        end
    end

    assign DadoLido1 = (RegLido1 == 3'b000) ? 8'h00 : regFile[RegLido1];
    assign DadoLido2 = (regLido2 == 3'b000) ? 8'h00 : regFile[regLido2];
    assign Dadoa0    = regFile[1];

endmodule

// File: tb/tb_nrisc_decode_stage.sv
// Scoreboard bench for nrisc_decode_stage: stimulus queues expected values each cycle,
// a monitor pops and compares them on the falling edge before the next write edge.
module tb_nrisc_decode_stage;

    logic       Clock = 1'b0;
    logic       Reset;
    logic [7:0] Instrucao;
    logic [7:0] DadoEscritoReg;
    logic       MemToReg, EscMem, LerMem, Branch, ULAFonte, EscReg, Jump, EscPc, MoveReg, RegDest;
    logic [1:0] ULAOp;
    logic [2:0] RegLido1, RegEscrito;
    logic [7:0] DadoLido1, DadoLido2, Dadoa0;

    nrisc_decode_stage dut (
        .Clock(Clock), .Reset(Reset), .Instrucao(Instrucao), .DadoEscritoReg(DadoEscritoReg),
        .MemToReg(MemToReg), .EscMem(EscMem), .LerMem(LerMem), .Branch(Branch),
        .ULAFonte(ULAFonte), .EscReg(EscReg), .Jump(Jump), .EscPc(EscPc),
        .MoveReg(MoveReg), .RegDest(RegDest), .ULAOp(ULAOp),
        .RegLido1(RegLido1), .RegEscrito(RegEscrito),
        .DadoLido1(DadoLido1), .DadoLido2(DadoLido2), .Dadoa0(Dadoa0)
    );

    always #5 Clock = ~Clock;

    // Observed-field selectors
    localparam int S_CTRL = 0, S_RL1 = 1, S_RESC = 2, S_DL1 = 3, S_DL2 = 4, S_A0 = 5;

    // {MemToReg,EscMem,LerMem,Branch,ULAFonte,EscReg,Jump,EscPc,MoveReg,RegDest,ULAOp}
    localparam logic [11:0] V_ADD  = 12'b0000_0101_0000;
    localparam logic [11:0] V_SUB  = 12'b0000_0101_0001;
    localparam logic [11:0] V_LW   = 12'b1010_1101_0000;
    localparam logic [11:0] V_SW   = 12'b0100_1001_0000;
    localparam logic [11:0] V_BEQ  = 12'b0001_0001_0001;
    localparam logic [11:0] V_J    = 12'b0000_0011_0000;
    localparam logic [11:0] V_MOV  = 12'b0000_0101_1100;
    localparam logic [11:0] V_ZERO = 12'b0000_0000_0000;

    string       nameQ[$];
    int          selQ[$];
    logic [11:0] expQ[$];

    int testsRun  = 0;
    int failCount = 0;

    function automatic logic [11:0] observe(int sel);
        case (sel)
            S_CTRL: return {MemToReg, EscMem, LerMem, Branch, ULAFonte, EscReg,
                            Jump, EscPc, MoveReg, RegDest, ULAOp};
            S_RL1:  return {9'd0, RegLido1};
            S_RESC: return {9'd0, RegEscrito};
            S_DL1:  return {4'd0, DadoLido1};
            S_DL2:  return {4'd0, DadoLido2};
            default: return {4'd0, Dadoa0};
        endcase
    endfunction

    // Monitor: drains the scoreboard once per cycle, away from the write edge
    initial begin
        forever begin
            @(negedge Clock);
            while (selQ.size() > 0) begin
                string       nm;
                int          sel;
                logic [11:0] exp;
                logic [11:0] act;
                nm  = nameQ.pop_front();
                sel = selQ.pop_front();
                exp = expQ.pop_front();
                act = observe(sel);
                testsRun++;
                if (act !== exp) begin
                    failCount++;
                    $display("FAIL %s: got 0x%03h, expected 0x%03h", nm, act, exp);
                end
            end
        end
    end

    task automatic expect_val(input string nm, input int sel, input logic [11:0] exp);
        nameQ.push_back(nm);
        selQ.push_back(sel);
        expQ.push_back(exp);
    endtask

    task automatic apply(input logic rst, input logic [7:0] instr, input logic [7:0] data);
        Reset          = rst;
        Instrucao      = instr;
        DadoEscritoReg = data;
    endtask

    // Let the monitor consume this cycle's checks, then cross the next rising edge
    task automatic end_cycle();
        @(negedge Clock);
        #1;
        if (selQ.size() != 0) begin
            testsRun++;
            failCount++;
            $display("FAIL scoreboard_drain: %0d pending, expected 0", selQ.size());
            nameQ.delete();
            selQ.delete();
            expQ.delete();
        end
        @(posedge Clock);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", testsRun, failCount + 1);
        $fatal(1);
    end

    localparam logic [11:0] SWEEP [0:6] = '{V_ADD, V_SUB, V_LW, V_SW, V_BEQ, V_J, V_MOV};

    initial begin
        // Reset edge with a write request to r3 that must be dropped
        apply(1'b1, 8'b000_11_000, 8'hAA);
        @(posedge Clock);
        #1;

        // Read sweep after reset using SW (no register writes)
        for (int b = 0; b < 8; b++) begin
            apply(1'b0, {3'b011, 2'b00, b[2:0]}, 8'h00);
            expect_val($sformatf("reset_dl2_r%0d", b), S_DL2, 12'h000);
            expect_val($sformatf("reset_a0_b%0d", b), S_A0, 12'h000);
            if (b == 0) expect_val("reset_ctrl_sw", S_CTRL, V_SW);
            end_cycle();
        end

        // ADD into r3; read in the same cycle still sees the old value
        apply(1'b0, 8'b000_11_000, 8'h5A);
        expect_val("add_ctrl", S_CTRL, V_ADD);
        expect_val("add_rl1", S_RL1, 12'h003);
        expect_val("add_resc", S_RESC, 12'h003);
        expect_val("add_dl1_old", S_DL1, 12'h000);
        end_cycle();
        apply(1'b0, 8'b011_11_011, 8'h00);
        expect_val("add_readback_dl2", S_DL2, 12'h05A);
        expect_val("add_readback_dl1", S_DL1, 12'h05A);
        end_cycle();

        // MOV into a0
        apply(1'b0, 8'b110_00_010, 8'h7F);
        expect_val("mov_ctrl", S_CTRL, V_MOV);
        expect_val("mov_resc", S_RESC, 12'h001);
        expect_val("mov_a0_old", S_A0, 12'h000);
        end_cycle();
        apply(1'b0, 8'b011_00_001, 8'h00);
        expect_val("mov_a0_new", S_A0, 12'h07F);
        expect_val("mov_dl2_r1", S_DL2, 12'h07F);
        end_cycle();

        // Write to r0 is discarded
        apply(1'b0, 8'b000_00_000, 8'hFF);
        expect_val("r0_resc", S_RESC, 12'h000);
        expect_val("r0_ctrl", S_CTRL, V_ADD);
        end_cycle();
        apply(1'b0, 8'b011_00_000, 8'h00);
        expect_val("r0_dl1", S_DL1, 12'h000);
        expect_val("r0_dl2", S_DL2, 12'h000);
        expect_val("r0_a0_kept", S_A0, 12'h07F);
        end_cycle();

        // r2 <= 0x11 for later halt checks
        apply(1'b0, 8'b000_10_000, 8'h11);
        end_cycle();

        // Decode sweep: field A=0 so writes hit r0, MOV rewrites a0 with the same 0x7F
        for (int op = 0; op < 7; op++) begin
            apply(1'b0, {op[2:0], 2'b00, 3'b010}, 8'h7F);
            expect_val($sformatf("sweep_ctrl_op%0d", op), S_CTRL, SWEEP[op]);
            expect_val($sformatf("sweep_dl2_op%0d", op), S_DL2, 12'h011);
            end_cycle();
        end

        // HALT: EscPc drops in its own cycle and stays down afterwards
        apply(1'b0, 8'b111_00_000, 8'h00);
        expect_val("halt_ctrl_now", S_CTRL, V_ZERO);
        end_cycle();
        apply(1'b0, 8'b000_10_000, 8'h33);
        expect_val("halted_add_ctrl", S_CTRL, V_ZERO);
        expect_val("halted_add_resc", S_RESC, 12'h002);
        end_cycle();
        apply(1'b0, 8'b110_00_010, 8'h44);
        expect_val("halted_mov_ctrl", S_CTRL, V_ZERO);
        expect_val("halted_r2_kept", S_DL2, 12'h011);
        end_cycle();
        apply(1'b0, 8'b011_10_001, 8'h00);
        expect_val("halted_sw_ctrl", S_CTRL, V_ZERO);
        expect_val("halted_a0_kept", S_A0, 12'h07F);
        expect_val("halted_dl1_r2", S_DL1, 12'h011);
        end_cycle();

        // Reset clears the flag and the registers, dropping the concurrent write
        apply(1'b1, 8'b000_10_000, 8'h55);
        end_cycle();
        apply(1'b0, 8'b000_10_000, 8'h66);
        expect_val("post_reset_ctrl", S_CTRL, V_ADD);
        expect_val("post_reset_dl1_r2", S_DL1, 12'h000);
        expect_val("post_reset_a0", S_A0, 12'h000);
        end_cycle();
        apply(1'b0, 8'b011_00_010, 8'h00);
        expect_val("post_reset_write_r2", S_DL2, 12'h066);
        end_cycle();

        $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
        $finish;
    end

endmodule

// File: doc/nrisc_decode_stage.md
# nrisc_decode_stage

Decode and register stage of the nRisc 8-bit processor. It decodes the 3-bit opcode into datapath control signals, expands the 2-bit destination/source field to a 3-bit register number, and holds the 8 x 8-bit register file. It sits between instruction fetch and the ALU/memory muxes of the nRisc datapath. It also implements a sticky HALT state.

## Interface
- No parameters.
- Clock  in  1  rising-edge clock for all state.
- Reset  in  1  synchronous, active-high; clears all registers and the halt flag.
- Instrucao  in  8  current instruction:
  - [7:5] opcode.
  - [4:3] register field A.
  - [2:0] register field B.
- DadoEscritoReg  in  8  write data, already selected by the external MemToReg/MoveReg muxes.
- MemToReg, EscMem, LerMem, Branch, ULAFonte, EscReg, Jump, EscPc, MoveReg, RegDest  out  1 each  control signals.
- ULAOp  out  2  ALU operation: 00 add, 01 sub, 10/11 unused.
- RegLido1  out  3  {1'b0, Instrucao[4:3]}.
- RegEscrito  out  3  RegDest ? 3'b001 : RegLido1.
- DadoLido1  out  8  register[RegLido1].
- DadoLido2  out  8  register[Instrucao[2:0]].
- Dadoa0  out  8  register 1 (a0), always driven.

## Operation
- Register file:
  - 8 entries, 8 bits each.
  - Register 0 is hardwired to 0: writes to it are ignored and it reads as 0.
  - Register 1 is a0.
- Reads are combinational, with no write-to-read bypass.
- Write occurs on a rising edge when EscReg=1, Reset=0 and RegEscrito≠0: register[RegEscrito] <= DadoEscritoReg.
- Decode is combinational from the opcode. Any signal not listed for an opcode is 0, and EscPc=1 unless stated.
  - 000 ADD: EscReg=1, ULAOp=00.
  - 001 SUB: EscReg=1, ULAOp=01.
  - 010 LW: LerMem=1, MemToReg=1, EscReg=1, ULAFonte=1, ULAOp=00.
  - 011 SW: EscMem=1, ULAFonte=1, ULAOp=00.
  - 100 BEQ: Branch=1, ULAOp=01.
  - 101 J: Jump=1.
  - 110 MOV: MoveReg=1, EscReg=1, RegDest=1 (destination is a0).
  - 111 HALT: all outputs 0, including EscPc.
- Halt flag:
  - Set on a rising edge when the opcode is 111 and Reset=0.
  - Cleared only by Reset.
  - While set, every control output is 0 (including EscPc and EscReg) regardless of opcode.
  - Register reads continue to work while halted.

## Timing
- Control outputs, RegLido1, RegEscrito and all read data are combinational, with zero-cycle latency from Instrucao or register state.
- Register writes and the halt flag update on the rising edge of Clock.
- Reset takes effect on the edge where it is sampled high:
  - All registers become 0x00 and the halt flag is cleared.
  - Any write requested in that same cycle is dropped.
- Reset state of outputs: DadoLido1, DadoLido2 and Dadoa0 read 0x00. Control outputs follow the opcode decode.
- The HALT instruction drives EscPc=0 combinationally in its own cycle. The flag holds EscPc=0 in all following cycles until Reset.
- Simultaneous write and read of the same register in one cycle: the read returns the old value, and the new value is visible after the edge.
- Write to register 0: silently discarded, no side effect.

## Test plan
- Reset then read: assert Reset for 1 edge, then sweep field B over 0..7. DadoLido2 must be 0x00 for every value, and Dadoa0 must be 0x00.
- ADD write and read back:
  - Instrucao=000_11_000, DadoEscritoReg=0x5A, clock once.
  - Expect RegEscrito=3'b011, EscReg=1, ULAOp=00.
  - Then field B=3'b011 reads DadoLido2=0x5A.
- MOV to a0: Instrucao=110_00_010, DadoEscritoReg=0x7F, clock once. Expect RegEscrito=3'b001, MoveReg=1, then Dadoa0=0x7F.
- Register 0 protection: Instrucao=000_00_000, DadoEscritoReg=0xFF, clock once. DadoLido1 stays 0x00.
- Decode sweep: apply opcodes 000..110 without clocking. Each opcode must produce exactly the control vector listed in Operation, with EscPc=1.
- HALT:
  - Apply 111, clock once. EscPc=0 immediately and after the edge.
  - Then apply 000_10_000 with DadoEscritoReg=0x33 and clock. Expect EscReg=0 and register 2 unchanged.
  - Assert Reset for 1 edge. The flag clears and opcode 000 again gives EscPc=1, EscReg=1.
